// File: rtl/updown_counter_mod.sv
// updown_counter_mod: parametrised synchronous up/down counter.
// Generalises the 4-bit load/count/hold counter with configurable width,
// modulus, wrap-or-saturate behaviour and cascade outputs (TC, CO, WRAP).
// Stage k of a multi-digit counter takes NCT = ~(CO of every lower stage),
// and all stages share NUD.
//
// Edge priority: RST > load (NLD=0) > count (NCT=0) > hold.
module updown_counter_mod #(
    parameter int     WIDTH     = 4,
    parameter longint MODULUS   = longint'(1) << WIDTH,
    parameter bit     SATURATE  = 1'b0,
    parameter longint RESET_VAL = 0
) (
    input  logic             CP,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic             NLD,
    input  logic             NCT,
    input  logic             NUD,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             CO,
    output logic             WRAP
);

    // Parameter legality, caught at elaboration rather than as odd behaviour.
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("updown_counter_mod: WIDTH must be in 1..32");
        end
        if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
            $error("updown_counter_mod: MODULUS must be in 2..2**WIDTH");
        end
        if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
            $error("updown_counter_mod: RESET_VAL must be < MODULUS");
        end
    endgenerate

    // Range ends and constants, all held at WIDTH bits so the step
    // arithmetic never needs a wider intermediate.
    localparam logic [WIDTH-1:0] max_val = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] rst_val = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] one     = WIDTH'(1);

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;
    logic             at_top;
    logic             at_bot;

    assign at_top = (q_r == max_val);
    assign at_bot = (q_r == '0);

    // Next-state selection for load / count / hold. D is only routed to
    // q_next in the load branch, so an unknown D cannot leak while NLD=1.
    always_comb begin
        q_next    = q_r;
        wrap_next = 1'b0;
        if (!NLD) begin
            // Out-of-range load data clamps to the top of the range.
            q_next = (D > max_val) ? max_val : D;
        end else if (!NCT) begin
            if (!NUD) begin
                if (at_top) begin
                    wrap_next = 1'b1;
                    q_next    = SATURATE ? q_r : '0;
                end else begin
                    q_next = q_r + one;
                end
            end else begin
                if (at_bot) begin
                    wrap_next = 1'b1;
                    q_next    = SATURATE ? q_r : max_val;
                end else begin
                    q_next = q_r - one;
                end
            end
        end
    end

    // Count register and wrap pulse; reset aborts any step on the same edge.
    always_ff @(posedge CP) begin
        if (RST) begin
            q_r    <= rst_val;
            wrap_r <= 1'b0;
        end else begin
            q_r    <= q_next;
            wrap_r <= wrap_next;
        end
    end

    // Terminal count tracks Q and the current direction with no register;
    // CO additionally requires this stage to be enabled.
    always_comb begin
        TC = NUD ? at_bot : at_top;
        CO = TC & ~NCT;
    end

    assign Q    = q_r;
    assign WRAP = wrap_r;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Testbench for updown_counter_mod: decade wrap, decade saturate (non-zero
// reset value), two-digit decade cascade, and 8-bit full-range instance.
module tb_updown_counter_mod;

    // ---------------- clock / reset block ----------------
    logic CP = 1'b0;
    always #5 CP = ~CP;

    // Instance a: WIDTH=4, MODULUS=10, wrap.
    logic       a_rst, a_nld, a_nct, a_nud;
    logic [3:0] a_d, a_q;
    logic       a_tc, a_co, a_wrap;
    // Instance s: WIDTH=4, MODULUS=10, saturate, RESET_VAL=5.
    logic       s_rst, s_nld, s_nct, s_nud;
    logic [3:0] s_d, s_q;
    logic       s_tc, s_co, s_wrap;
    // Cascade: two decade stages sharing reset/load/direction.
    logic       c_rst, c_nld, c_nud, c0_nct;
    logic [3:0] c_d, c0_q, c1_q;
    logic       c0_tc, c0_co, c0_wrap, c1_tc, c1_co, c1_wrap;
    // Instance f: WIDTH=8, default MODULUS.
    logic       f_rst, f_nld, f_nct, f_nud;
    logic [7:0] f_d, f_q;
    logic       f_tc, f_co, f_wrap;

    updown_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .RESET_VAL(0)) u_a (
        .CP(CP), .RST(a_rst), .D(a_d), .NLD(a_nld), .NCT(a_nct), .NUD(a_nud),
        .Q(a_q), .TC(a_tc), .CO(a_co), .WRAP(a_wrap));

    updown_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1), .RESET_VAL(5)) u_s (
        .CP(CP), .RST(s_rst), .D(s_d), .NLD(s_nld), .NCT(s_nct), .NUD(s_nud),
        .Q(s_q), .TC(s_tc), .CO(s_co), .WRAP(s_wrap));

    updown_counter_mod #(.WIDTH(4), .MODULUS(10)) u_c0 (
        .CP(CP), .RST(c_rst), .D(c_d), .NLD(c_nld), .NCT(c0_nct), .NUD(c_nud),
        .Q(c0_q), .TC(c0_tc), .CO(c0_co), .WRAP(c0_wrap));

    updown_counter_mod #(.WIDTH(4), .MODULUS(10)) u_c1 (
        .CP(CP), .RST(c_rst), .D(c_d), .NLD(c_nld), .NCT(~c0_co), .NUD(c_nud),
        .Q(c1_q), .TC(c1_tc), .CO(c1_co), .WRAP(c1_wrap));

    updown_counter_mod #(.WIDTH(8)) u_f (
        .CP(CP), .RST(f_rst), .D(f_d), .NLD(f_nld), .NCT(f_nct), .NUD(f_nud),
        .Q(f_q), .TC(f_tc), .CO(f_co), .WRAP(f_wrap));

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic compare_next(input logic [31:0] got);
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_empty got=%0h exp=<entry>", got);
        end else begin
            check(tag_q.pop_front(), got, exp_q.pop_front());
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    // Each step drives inputs, records {WRAP,Q} expected after the edge,
    // then pops and compares it against the DUT.
    task automatic a_step(input string tag, input logic rst, input logic nld, input logic nct,
                          input logic nud, input logic [3:0] d, input logic ew, input logic [3:0] eq);
        a_rst = rst; a_nld = nld; a_nct = nct; a_nud = nud; a_d = d;
        push_exp(tag, 32'({ew, eq}));
        tick();
        compare_next(32'({a_wrap, a_q}));
    endtask

    task automatic s_step(input string tag, input logic rst, input logic nld, input logic nct,
                          input logic nud, input logic [3:0] d, input logic ew, input logic [3:0] eq);
        s_rst = rst; s_nld = nld; s_nct = nct; s_nud = nud; s_d = d;
        push_exp(tag, 32'({ew, eq}));
        tick();
        compare_next(32'({s_wrap, s_q}));
    endtask

    task automatic f_step(input string tag, input logic nld, input logic nct,
                          input logic nud, input logic [7:0] d, input logic ew, input logic [7:0] eq);
        f_rst = 1'b0; f_nld = nld; f_nct = nct; f_nud = nud; f_d = d;
        push_exp(tag, 32'({ew, eq}));
        tick();
        compare_next(32'({f_wrap, f_q}));
    endtask

    // Two-digit decimal model: value v in 0..99, expected {wrap1,wrap0,q1,q0}.
    task automatic cascade_run(input string tag, input logic nud, input int steps);
        int v;
        int p;
        logic w0, w1;
        v = 0;
        c_nud = nud; c0_nct = 1'b0; c_nld = 1'b1; c_rst = 1'b0;
        for (int i = 0; i < steps; i++) begin
            p = v;
            if (!nud) begin
                v  = (p + 1) % 100;
                w0 = (p % 10 == 9);
                w1 = (p == 99);
            end else begin
                v  = (p + 99) % 100;
                w0 = (p % 10 == 0);
                w1 = (p == 0);
            end
            push_exp(tag, 32'({w1, w0, 4'(v / 10), 4'(v % 10)}));
            tick();
            compare_next(32'({c1_wrap, c0_wrap, c1_q, c0_q}));
        end
        c0_nct = 1'b1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        a_rst = 1'b1; a_nld = 1'b1; a_nct = 1'b1; a_nud = 1'b1; a_d = 4'd0;
        s_rst = 1'b1; s_nld = 1'b1; s_nct = 1'b1; s_nud = 1'b1; s_d = 4'd0;
        c_rst = 1'b1; c_nld = 1'b1; c0_nct = 1'b1; c_nud = 1'b0; c_d = 4'd0;
        f_rst = 1'b1; f_nld = 1'b1; f_nct = 1'b1; f_nud = 1'b0; f_d = 8'd0;
        tick();
        tick();

        // Reset state.
        check("a_rst_q",    32'(a_q),    32'd0);
        check("a_rst_wrap", 32'(a_wrap), 32'd0);
        check("a_rst_tc",   32'(a_tc),   32'd1);
        check("a_rst_co",   32'(a_co),   32'd0);
        check("s_rst_q",    32'(s_q),    32'd5);
        check("f_rst_q",    32'(f_q),    32'd0);

        // Load, clamp.
        a_step("a_load7",   1'b0, 1'b0, 1'b1, 1'b1, 4'd7,  1'b0, 4'd7);
        a_step("a_clamp12", 1'b0, 1'b0, 1'b1, 1'b1, 4'd12, 1'b0, 4'd9);

        // Up wrap from 8: 9, 0, 1.
        a_step("a_load8",   1'b0, 1'b0, 1'b1, 1'b0, 4'd8, 1'b0, 4'd8);
        a_step("a_up9",     1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd9);
        check("a_tc_at9", 32'(a_tc), 32'd1);
        check("a_co_at9", 32'(a_co), 32'd1);
        a_step("a_up0",     1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
        a_step("a_up1",     1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd1);

        // Priority: load beats count.
        a_step("a_load9",   1'b0, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 4'd9);
        a_step("a_ld_over_ct", 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 4'd3);
        // Reset beats load.
        a_step("a_rst_over_ld", 1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 1'b0, 4'd0);
        // Reset mid-count at 5.
        a_step("a_load4",   1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 1'b0, 4'd4);
        a_step("a_up5",     1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd5);
        a_step("a_rst_mid", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        // Reset on a terminal step suppresses WRAP.
        a_step("a_load9b",  1'b0, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 4'd9);
        a_step("a_rst_term", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        // Down wrap from 0 to 9, then direction flip re-evaluates TC at once.
        a_step("a_dn9",     1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 4'd9);
        check("a_tc_dn_at9", 32'(a_tc), 32'd0);
        a_nud = 1'b0;
        #1;
        check("a_tc_flip",  32'(a_tc), 32'd1);
        a_nct = 1'b1;
        #1;
        check("a_co_hold",  32'(a_co), 32'd0);
        a_step("a_hold",    1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd9);

        // Saturating instance: down from 1 -> 0,0,0 with WRAP 0,1,1.
        s_step("s_load1",   1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 4'd1);
        s_step("s_dn0",     1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0);
        s_step("s_sat0a",   1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 4'd0);
        s_step("s_sat0b",   1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 4'd0);
        s_step("s_hold0",   1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0);
        s_step("s_load8",   1'b0, 1'b0, 1'b1, 1'b0, 4'd8, 1'b0, 4'd8);
        s_step("s_up9",     1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd9);
        s_step("s_sat9",    1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd9);
        s_step("s_clamp15", 1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0, 4'd9);
        s_step("s_rst5",    1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 4'd5);

        // Cascade: up 101 steps (through 99 -> 00 -> 01), then down from 00.
        c_rst = 1'b1;
        tick();
        check("c_rst_q", 32'({c1_q, c0_q}), 32'h00);
        cascade_run("c_up", 1'b0, 101);
        c_rst = 1'b1;
        tick();
        cascade_run("c_dn", 1'b1, 12);

        // Full 8-bit range.
        f_step("f_load255", 1'b0, 1'b1, 1'b0, 8'd255, 1'b0, 8'd255);
        f_step("f_up_roll", 1'b1, 1'b0, 1'b0, 8'd0,   1'b1, 8'd0);
        f_step("f_dn_roll", 1'b1, 1'b0, 1'b1, 8'd0,   1'b1, 8'd255);
        for (int i = 0; i < 5; i++) begin
            f_step("f_hold", 1'b1, 1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0, 8'd255);
        end
        for (int i = 0; i < 4; i++) begin
            f_step("f_dn", 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 8'(254 - i));
        end

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
